// File: rtl/line_buf_pkg.sv
// Shared definitions for the line window buffer.
// MAX_LINES : upper bound on the number of stored previous lines.
// BANK_W    : width of a bank pointer able to address MAX_LINES banks.
// bank_idx  : bank holding the line k rows above the one being written,
//             i.e. (wr_bank - k) mod n_lines, for 0 <= k <= n_lines.
package line_buf_pkg;

    localparam int MAX_LINES = 4;
    localparam int BANK_W    = 2;

    function automatic logic [BANK_W-1:0] bank_idx(
        input logic [BANK_W-1:0] wr_bank,
        input int                k,
        input int                n_lines
    );
        int t;
        // Adding n_lines keeps the dividend non-negative for k <= n_lines.
        t = int'(wr_bank) + n_lines - k;
        return BANK_W'(t % n_lines);
    endfunction

endpackage

// File: rtl/line_window_buf_if.sv
// Pixel stream in / vertical column out bundle for line_window_buf.
// in_valid/in_data/in_eol/in_sof : incoming pixel stream (no back-pressure).
// out_valid/out_col/out_x        : one column per accepted pixel, 1 cycle later.
// out_line_mask                  : bit k set when slice k of out_col is real.
// overflow                       : sticky, a line ran past 2**ADDR_WIDTH pixels.
// master drives the stream; slave is the buffer.
interface line_window_buf_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int N_LINES    = 2
);
    logic                              in_valid;
    logic [DATA_WIDTH-1:0]             in_data;
    logic                              in_eol;
    logic                              in_sof;
    logic                              out_valid;
    logic [DATA_WIDTH*(N_LINES+1)-1:0] out_col;
    logic [ADDR_WIDTH-1:0]             out_x;
    logic [N_LINES:0]                  out_line_mask;
    logic                              overflow;

    modport master (
        output in_valid, in_data, in_eol, in_sof,
        input  out_valid, out_col, out_x, out_line_mask, overflow
    );

    modport slave (
        input  in_valid, in_data, in_eol, in_sof,
        output out_valid, out_col, out_x, out_line_mask, overflow
    );
endinterface

// File: rtl/line_bank_ram.sv
// Single-clock simple dual-port RAM holding one video line.
// clk     : rising-edge clock
// we      : write enable; wr_addr/wr_data written at the edge
// re      : read enable; rd_data updated from rd_addr at the edge
// rd_data : registered read data (1-cycle latency); a read and write to the
//           same address in one cycle return the previous contents.
// Contents are deliberately not reset.
module line_bank_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Non-blocking write and read in the same edge give read-old behaviour.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/line_window_buf.sv
// Line window buffer: for every incoming pixel, emits the vertical column made
// of that pixel plus the pixels at the same x in the N_LINES previous lines.
// clk   : sole clock, rising edge
// rst_n : asynchronous active-low reset (RAM contents are kept)
// bus   : line_window_buf_if slave (pixel stream in, column stream out)
module line_window_buf
    import line_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int N_LINES    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    line_window_buf_if.slave  bus
);

    localparam int                COL_W     = DATA_WIDTH * (N_LINES + 1);
    localparam int                FILL_W    = $clog2(MAX_LINES + 1);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(N_LINES - 1);
    localparam logic [FILL_W-1:0] FULL      = FILL_W'(N_LINES);
    localparam logic [ADDR_WIDTH-1:0] X_MAX = {ADDR_WIDTH{1'b1}};

    logic [ADDR_WIDTH-1:0] x_q, x_d, x_eff;
    logic [BANK_W-1:0]     wr_bank_q, wr_bank_d, wr_bank_eff;
    logic [BANK_W-1:0]     acc_bank_q, acc_bank_d;
    logic [FILL_W-1:0]     fill_q, fill_d, fill_eff;
    logic                  ovf_q, ovf_d, ovf_eff;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] pix_q, pix_d;
    logic [ADDR_WIDTH-1:0] out_x_q, out_x_d;
    logic [N_LINES:0]      mask_q, mask_d;
    logic                  sof, line_end, wrap;
    logic [N_LINES-1:0]    bank_we;
    logic [DATA_WIDTH-1:0] bank_rd [N_LINES];
    logic [COL_W-1:0]      col;

    // Start-of-frame resets the line state before the pixel itself is used.
    always_comb begin
        sof         = bus.in_valid & bus.in_sof;
        x_eff       = sof ? '0 : x_q;
        wr_bank_eff = sof ? '0 : wr_bank_q;
        fill_eff    = sof ? '0 : fill_q;
        ovf_eff     = sof ? 1'b0 : ovf_q;
        // A full-length line without eol is closed as if eol were present.
        wrap        = (x_eff == X_MAX) & ~bus.in_eol;
        line_end    = bus.in_eol | (x_eff == X_MAX);
    end

    always_comb begin
        x_d         = x_q;
        wr_bank_d   = wr_bank_q;
        acc_bank_d  = acc_bank_q;
        fill_d      = fill_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        pix_d       = pix_q;
        out_x_d     = out_x_q;
        mask_d      = mask_q;
        if (bus.in_valid) begin
            x_d         = line_end ? '0 : x_eff + 1'b1;
            wr_bank_d   = !line_end ? wr_bank_eff :
                          (wr_bank_eff == LAST_BANK) ? '0 : wr_bank_eff + 1'b1;
            fill_d      = (line_end && fill_eff < FULL) ? fill_eff + 1'b1 : fill_eff;
            ovf_d       = ovf_eff | wrap;
            out_valid_d = 1'b1;
            pix_d       = bus.in_data;
            out_x_d     = x_eff;
            // Bank selection for the output mux uses the pointer seen now.
            acc_bank_d  = wr_bank_eff;
            for (int k = 0; k <= N_LINES; k++) begin
                mask_d[k] = (k <= int'(fill_eff));
            end
        end
    end

    always_comb begin
        for (int j = 0; j < N_LINES; j++) begin
            bank_we[j] = bus.in_valid && (int'(wr_bank_eff) == j);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            wr_bank_q   <= '0;
            acc_bank_q  <= '0;
            fill_q      <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            pix_q       <= '0;
            out_x_q     <= '0;
            mask_q      <= '0;
        end else begin
            x_q         <= x_d;
            wr_bank_q   <= wr_bank_d;
            acc_bank_q  <= acc_bank_d;
            fill_q      <= fill_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            pix_q       <= pix_d;
            out_x_q     <= out_x_d;
            mask_q      <= mask_d;
        end
    end

    for (genvar g = 0; g < N_LINES; g++) begin : g_bank
        line_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .clk     (clk),
            .we      (bank_we[g]),
            .wr_addr (x_eff),
            .wr_data (bus.in_data),
            .re      (bus.in_valid),
            .rd_addr (x_eff),
            .rd_data (bank_rd[g])
        );
    end

    // Masked-off slices read as zero, so stale RAM data never leaks out; the
    // reset mask also forces the whole column to zero during reset.
    always_comb begin
        logic [BANK_W-1:0] sel;
        col                 = '0;
        col[DATA_WIDTH-1:0] = pix_q;
        for (int k = 1; k <= N_LINES; k++) begin
            sel = bank_idx(acc_bank_q, k, N_LINES);
            for (int j = 0; j < N_LINES; j++) begin
                if (mask_q[k] && (int'(sel) == j)) begin
                    col[k*DATA_WIDTH +: DATA_WIDTH] = bank_rd[j];
                end
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_col       = col;
    assign bus.out_x         = out_x_q;
    assign bus.out_line_mask = mask_q;
    assign bus.overflow      = ovf_q;

endmodule

// File: tb/tb_line_window_buf.sv
module tb_line_window_buf;

    localparam int DW  = 16;
    localparam int AW  = 3;
    localparam int N   = 2;
    localparam int LEN = 8;
    localparam int OW  = 1 + AW + (N + 1) + DW * (N + 1) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    line_window_buf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_LINES(N)) bus ();

    line_window_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_LINES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: completed lines since frame start (newest last), the line
    // being assembled, the current column and the sticky overflow flag.
    logic [DW*LEN-1:0] hist[$];
    logic [DW*LEN-1:0] cur_line;
    int                cx;
    bit                movf;
    logic [OW-1:0]     exp_obs;

    task automatic model_clear();
        hist.delete();
        cx   = 0;
        movf = 1'b0;
    endtask

    // Drive one pixel, update the reference, and leave expected outputs in
    // exp_obs; returns 1 ns after the accepting edge.
    task automatic send(input logic [DW-1:0] d, input bit eol, input bit sof);
        logic [DW*(N+1)-1:0] ecol;
        logic [N:0]          emask;
        logic [DW*LEN-1:0]   tmp;
        int                  nf;
        int                  ex;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_eol   = eol;
        bus.in_sof   = sof;
        if (sof) model_clear();
        nf    = (hist.size() > N) ? N : hist.size();
        ex    = cx;
        ecol  = '0;
        emask = '0;
        ecol[DW-1:0] = d;
        emask[0]     = 1'b1;
        for (int k = 1; k <= N; k++) begin
            if (k <= nf) begin
                emask[k] = 1'b1;
                tmp = hist[hist.size() - k];
                ecol[k*DW +: DW] = tmp[ex*DW +: DW];
            end
        end
        cur_line[ex*DW +: DW] = d;
        if (eol || ex == LEN - 1) begin
            if (!eol) movf = 1'b1;
            hist.push_back(cur_line);
            if (hist.size() > N) void'(hist.pop_front());
            cx = 0;
        end else begin
            cx = ex + 1;
        end
        exp_obs = {1'b1, AW'(ex), emask, ecol, movf};
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_eol   = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_eol   = 1'b0;
        bus.in_sof   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_col !== '0) begin errors++; $display("FAIL reset_col got %h exp 0", bus.out_col); end
        checks++; if (bus.out_x !== '0) begin errors++; $display("FAIL reset_x got %0d exp 0", bus.out_x); end
        checks++; if (bus.out_line_mask !== '0) begin errors++; $display("FAIL reset_mask got %b exp 0", bus.out_line_mask); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_lines();
        logic [DW*(N+1)-1:0] want;
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < LEN; i++) begin
                send(DW'(l * LEN + i), i == LEN - 1, 1'b0);
                checks++;
                if ({bus.out_valid, bus.out_x, bus.out_line_mask, bus.out_col, bus.overflow} !== exp_obs) begin
                    errors++;
                    $display("FAIL lines l=%0d i=%0d got %h exp %h", l, i,
                             {bus.out_valid, bus.out_x, bus.out_line_mask, bus.out_col, bus.overflow}, exp_obs);
                end
                if (l == 2 && i == 5) begin
                    want = {16'd5, 16'd13, 16'd21};
                    checks++;
                    if (bus.out_col !== want || bus.out_line_mask !== 3'b111) begin
                        errors++;
                        $display("FAIL lines_col3 got %h/%b exp %h/111", bus.out_col, bus.out_line_mask, want);
                    end
                end
            end
        end
    endtask

    task automatic test_gaps();
        for (int i = 0; i < LEN; i++) begin
            send(DW'($urandom), i == LEN - 1, 1'b0);
            checks++;
            if ({bus.out_valid, bus.out_x, bus.out_line_mask, bus.out_col, bus.overflow} !== exp_obs) begin
                errors++;
                $display("FAIL gaps i=%0d got %h exp %h", i,
                         {bus.out_valid, bus.out_x, bus.out_line_mask, bus.out_col, bus.overflow}, exp_obs);
            end
            idle();
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL gaps_idle i=%0d got %b exp 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 2 * LEN; i++) begin
            send(DW'(100 + i), i == 2 * LEN - 1, i == 0);
            checks++;
            if ({bus.out_valid, bus.out_x, bus.out_line_mask, bus.out_col, bus.overflow} !== exp_obs) begin
                errors++;
                $display("FAIL ovf i=%0d got %h exp %h", i,
                         {bus.out_valid, bus.out_x, bus.out_line_mask, bus.out_col, bus.overflow}, exp_obs);
            end
            if (i == LEN) begin
                checks++;
                if (bus.out_x !== '0 || bus.out_col[2*DW-1:DW] !== 16'd100 || bus.overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_wrap got x=%0d s1=%0d ovf=%b exp x=0 s1=100 ovf=1",
                             bus.out_x, bus.out_col[2*DW-1:DW], bus.overflow);
                end
            end
        end
    endtask

    task automatic test_sof();
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < LEN; i++) begin
                send(DW'($urandom), i == LEN - 1, l == 3 && i == 0);
                checks++;
                if ({bus.out_valid, bus.out_x, bus.out_line_mask, bus.out_col, bus.overflow} !== exp_obs) begin
                    errors++;
                    $display("FAIL sof l=%0d i=%0d got %h exp %h", l, i,
                             {bus.out_valid, bus.out_x, bus.out_line_mask, bus.out_col, bus.overflow}, exp_obs);
                end
                if (l == 3 && i == 0) begin
                    checks++;
                    if (bus.out_line_mask !== 3'b001 || bus.overflow !== 1'b0) begin
                        errors++;
                        $display("FAIL sof_clear got mask=%b ovf=%b exp 001/0", bus.out_line_mask, bus.overflow);
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < LEN + 3; i++) begin
            send(DW'($urandom), i == LEN - 1, 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_x, bus.out_line_mask, bus.out_col, bus.overflow} !== '0) begin
            errors++;
            $display("FAIL async_rst got %h exp 0",
                     {bus.out_valid, bus.out_x, bus.out_line_mask, bus.out_col, bus.overflow});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < LEN; i++) begin
            send(DW'($urandom), i == LEN - 1, 1'b0);
            checks++;
            if ({bus.out_valid, bus.out_x, bus.out_line_mask, bus.out_col, bus.overflow} !== exp_obs) begin
                errors++;
                $display("FAIL post_rst i=%0d got %h exp %h", i,
                         {bus.out_valid, bus.out_x, bus.out_line_mask, bus.out_col, bus.overflow}, exp_obs);
            end
            if (i == 0) begin
                checks++;
                if (bus.out_line_mask !== 3'b001 || bus.out_x !== '0) begin
                    errors++;
                    $display("FAIL post_rst_first got mask=%b x=%0d exp 001/0", bus.out_line_mask, bus.out_x);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int l = 0; l < 8; l++) begin
            for (int i = 0; i < LEN; i++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    idle();
                    checks++;
                    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rand_idle l=%0d got %b exp 0", l, bus.out_valid); end
                end
                send(DW'($urandom), i == LEN - 1, i == 0 && $urandom_range(0, 3) == 0);
                checks++;
                if ({bus.out_valid, bus.out_x, bus.out_line_mask, bus.out_col, bus.overflow} !== exp_obs) begin
                    errors++;
                    $display("FAIL rand l=%0d i=%0d got %h exp %h", l, i,
                             {bus.out_valid, bus.out_x, bus.out_line_mask, bus.out_col, bus.overflow}, exp_obs);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lines();
        test_gaps();
        test_overflow();
        test_sof();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
